// File: rtl/complex_coeff_pkg.sv
// Shared types and default coefficient tables for the complex coefficient loader.
// Bank 1 is bank 0 with both components negated and saturated.
package complex_coeff_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  localparam int COEFF_INDEX_WIDTH = 10;
  localparam int MAX_LENGTH = 1023;
  localparam int TABLE_TAPS = 12;

  localparam int BANK0_RE [TABLE_TAPS] = '{
    3, 2, 17, 0,
    55, 120, 123, 56,
    -99, -109, 23, -60
  };

  localparam int BANK0_IM [TABLE_TAPS] = '{
    7, 0, 5, -3,
    -103, -111, -24, 96,
    -32, -76, -14, 10
  };

  function automatic int sat(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Banks beyond the two defined tables, and indices past the table, read 0.
  function automatic int tap_val(
    input int bank,
    input int idx,
    input bit im,
    input int w
  );
    int v;
    if (idx >= TABLE_TAPS || bank > 1) return 0;
    v = im ? BANK0_IM[idx] : BANK0_RE[idx];
    if (bank == 1) v = -v;
    return sat(v, w);
  endfunction

endpackage

// File: rtl/complex_coeff_rom.sv
// Combinational coefficient ROM, NUM_BANKS x LENGTH complex taps,
// addressed by {bank, index}; out-of-range reads return 0.
module complex_coeff_rom
  import complex_coeff_pkg::*;
#(
  parameter int LENGTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BANKS = 2,
  parameter int BANK_BITS = 1
) (
  input  logic [BANK_BITS-1:0]         bank,
  input  logic [COEFF_INDEX_WIDTH-1:0] index,
  output logic [DATA_WIDTH-1:0]        re,
  output logic [DATA_WIDTH-1:0]        im
);

  localparam int DEPTH = NUM_BANKS * LENGTH;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] re_tab [DEPTH];
  logic [DATA_WIDTH-1:0] im_tab [DEPTH];
  logic [AW-1:0] addr;
  logic hit;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar i = 0; i < LENGTH; i++) begin : g_tap
      assign re_tab[b*LENGTH+i] =
        DATA_WIDTH'(tap_val(b, i, 1'b0, DATA_WIDTH));
      assign im_tab[b*LENGTH+i] =
        DATA_WIDTH'(tap_val(b, i, 1'b1, DATA_WIDTH));
    end
  end

  assign hit = (32'(index) < LENGTH) && (32'(bank) < NUM_BANKS);

  always_comb begin
    addr = '0;
    if (hit) addr = AW'(32'(bank) * LENGTH + 32'(index));
  end

  assign re = hit ? re_tab[addr] : '0;
  assign im = hit ? im_tab[addr] : '0;

endmodule

// File: rtl/complex_coeff_loader.sv
// Streams one complex coefficient bank into the matched-filter taps over valid/ready.
// Define COMPLEX_COEFF_CONJUGATE_EN to build the saturating conjugation stage.
module complex_coeff_loader
  import complex_coeff_pkg::*;
#(
  parameter int LENGTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BANKS = 2,
  parameter int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [BANK_BITS-1:0]         bankSelect,
  input  logic                         reverseOrder,
  input  logic                         conjugate,
  input  logic                         coeffReady,
  output logic                         coeffValid,
  output logic [DATA_WIDTH-1:0]        coefficientOutRe,
  output logic [DATA_WIDTH-1:0]        coefficientOutIm,
  output logic [COEFF_INDEX_WIDTH-1:0] coeffIndex,
  output logic                         busy,
  output logic                         filterSetFlag
);

  localparam int IW = COEFF_INDEX_WIDTH;
  localparam logic [IW-1:0] LAST = IW'(LENGTH - 1);

  state_t state;
  logic [BANK_BITS-1:0] bank_q;
  logic rev_q;

  logic accept;
  logic last_tap;
  logic [BANK_BITS-1:0] bank_in;
  logic [BANK_BITS-1:0] rom_bank;
  logic [IW-1:0] first_idx;
  logic [IW-1:0] step_idx;
  logic [IW-1:0] rom_idx;
  logic signed [DATA_WIDTH-1:0] rom_re;
  logic signed [DATA_WIDTH-1:0] rom_im;
  logic signed [DATA_WIDTH-1:0] im_out;

  assign accept = start && (state != LOAD);
  assign bank_in = (32'(bankSelect) < NUM_BANKS) ? bankSelect : '0;
  assign first_idx = reverseOrder ? LAST : '0;
  assign step_idx = rev_q ? coeffIndex - IW'(1)
                          : coeffIndex + IW'(1);
  assign last_tap = rev_q ? (coeffIndex == '0)
                          : (coeffIndex == LAST);

  // The ROM looks ahead: on start it serves the first tap, else the next one.
  assign rom_bank = accept ? bank_in : bank_q;
  assign rom_idx = accept ? first_idx : step_idx;

  complex_coeff_rom #(
    .LENGTH    (LENGTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_BANKS (NUM_BANKS),
    .BANK_BITS (BANK_BITS)
  ) u_rom (
    .bank (rom_bank),
    .index(rom_idx),
    .re   (rom_re),
    .im   (rom_im)
  );

`ifdef COMPLEX_COEFF_CONJUGATE_EN
  localparam logic signed [DATA_WIDTH-1:0] S_MIN =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic conj_q;
  logic conj_sel;

  assign conj_sel = accept ? conjugate : conj_q;
  assign im_out = !conj_sel ? rom_im
                : (rom_im == S_MIN) ? ~S_MIN
                : -rom_im;

  always_ff @(posedge clock) begin
    if (reset) conj_q <= 1'b0;
    else if (accept) conj_q <= conjugate;
  end
`else
  logic unused_conjugate;
  assign unused_conjugate = conjugate;
  assign im_out = rom_im;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      bank_q <= '0;
      rev_q <= 1'b0;
      coeffValid <= 1'b0;
      coefficientOutRe <= '0;
      coefficientOutIm <= '0;
      coeffIndex <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= LOAD;
            bank_q <= bank_in;
            rev_q <= reverseOrder;
            coeffValid <= 1'b1;
            coefficientOutRe <= rom_re;
            coefficientOutIm <= im_out;
            coeffIndex <= first_idx;
          end
        end
        LOAD: begin
          if (coeffReady) begin
            if (last_tap) begin
              state <= DONE;
              coeffValid <= 1'b0;
              coefficientOutRe <= '0;
              coefficientOutIm <= '0;
              coeffIndex <= '0;
            end else begin
              coefficientOutRe <= rom_re;
              coefficientOutIm <= im_out;
              coeffIndex <= step_idx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == LOAD);
  assign filterSetFlag = (state == DONE);

endmodule

// File: tb/tb_complex_coeff_loader.sv
// Directed bench for complex_coeff_loader (12 taps, 8-bit, 2 banks).
// Expected taps come from a local copy of the published coefficient tables.
module tb_complex_coeff_loader;

  localparam int N = 12;

  localparam int RE0 [N] = '{
    3, 2, 17, 0, 55, 120, 123, 56, -99, -109, 23, -60
  };
  localparam int IM0 [N] = '{
    7, 0, 5, -3, -103, -111, -24, 96, -32, -76, -14, 10
  };

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [0:0] bankSelect = 1'b0;
  logic reverseOrder = 1'b0;
  logic conjugate = 1'b0;
  logic coeffReady = 1'b0;
  logic coeffValid;
  logic [7:0] coefficientOutRe;
  logic [7:0] coefficientOutIm;
  logic [9:0] coeffIndex;
  logic busy;
  logic filterSetFlag;

  int n_vec = 0;
  int n_err = 0;

  complex_coeff_loader #(
    .LENGTH    (N),
    .DATA_WIDTH(8),
    .NUM_BANKS (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .bankSelect      (bankSelect),
    .reverseOrder    (reverseOrder),
    .conjugate       (conjugate),
    .coeffReady      (coeffReady),
    .coeffValid      (coeffValid),
    .coefficientOutRe(coefficientOutRe),
    .coefficientOutIm(coefficientOutIm),
    .coeffIndex      (coeffIndex),
    .busy            (busy),
    .filterSetFlag   (filterSetFlag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int ref_re(input int bank, input int e);
    return (bank == 1) ? -RE0[e] : RE0[e];
  endfunction

  function automatic int ref_im(input int bank, input int e, input bit conj);
    int v;
    v = (bank == 1) ? -IM0[e] : IM0[e];
`ifdef COMPLEX_COEFF_CONJUGATE_EN
    if (conj) v = (v == -128) ? 127 : -v;
`else
    if (conj) v = v;
`endif
    return v;
  endfunction

  task automatic check_idle(input string tag, input int flag);
    chk({tag, ".valid"}, int'(coeffValid), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".flag"}, int'(filterSetFlag), flag);
    chk({tag, ".re"}, int'($signed(coefficientOutRe)), 0);
    chk({tag, ".im"}, int'($signed(coefficientOutIm)), 0);
    chk({tag, ".idx"}, int'(coeffIndex), 0);
  endtask

  task automatic check_tap(
    input string tag,
    input int bank,
    input bit conj,
    input int e
  );
    string t;
    t = $sformatf("%s[%0d]", tag, e);
    chk({t, ".valid"}, int'(coeffValid), 1);
    chk({t, ".busy"}, int'(busy), 1);
    chk({t, ".flag"}, int'(filterSetFlag), 0);
    chk({t, ".re"}, int'($signed(coefficientOutRe)), ref_re(bank, e));
    chk({t, ".im"}, int'($signed(coefficientOutIm)), ref_im(bank, e, conj));
    chk({t, ".idx"}, int'(coeffIndex), e);
  endtask

  // Full load: optional stall before the transfer of stall_idx, and an
  // optional stray start (with flipped controls) while pulse_idx is shown.
  task automatic load_check(
    input string tag,
    input int bank,
    input bit rev,
    input bit conj,
    input int stall_idx,
    input int stall_n,
    input int pulse_idx
  );
    int e;
    bankSelect = 1'(bank);
    reverseOrder = rev;
    conjugate = conj;
    coeffReady = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < N; t++) begin
      e = rev ? N - 1 - t : t;
      if (e == stall_idx) begin
        coeffReady = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check_tap({tag, ".hold"}, bank, conj, e);
          tick();
        end
        coeffReady = 1'b1;
      end
      check_tap(tag, bank, conj, e);
      if (e == pulse_idx) begin
        start = 1'b1;
        reverseOrder = !rev;
        bankSelect = ~bankSelect;
        conjugate = !conj;
      end
      tick();
      start = 1'b0;
    end
    check_idle({tag, ".done"}, 1);
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    check_idle("reset", 0);
    reset = 1'b0;
    tick();
    check_idle("idle", 0);
    coeffReady = 1'b1;
    tick();
    check_idle("idle_rdy", 0);

    load_check("fwd", 0, 1'b0, 1'b0, -1, 0, -1);
    coeffReady = 1'b0;
    repeat (3) tick();
    check_idle("done_hold", 1);

    load_check("rev", 0, 1'b1, 1'b0, -1, 0, -1);
    load_check("stall", 0, 1'b0, 1'b0, 4, 3, -1);
    load_check("conj_b0", 0, 1'b0, 1'b1, -1, 0, -1);
    load_check("conj_b1", 1, 1'b0, 1'b1, -1, 0, -1);
    load_check("b1_rev", 1, 1'b1, 1'b0, -1, 0, -1);
    load_check("pulse", 0, 1'b0, 1'b0, -1, 0, 6);

    bankSelect = 1'b0;
    reverseOrder = 1'b0;
    conjugate = 1'b0;
    coeffReady = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      check_tap("abort", 0, 1'b0, t);
      tick();
    end
    check_tap("abort", 0, 1'b0, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("abort_rst", 0);
    tick();
    check_idle("abort_idle", 0);

    load_check("reload", 0, 1'b0, 1'b0, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
